ysyx_22050039_exu_sequencer: RTL
================================

// Module: ysyx_22050039_exu_sequencer
// PURPOSE
//  Execute-stage controller between IDU and WBU. Accepts one decoded op per handshake.
//  Add ops complete in one cycle. Multiplies use an iterative shift-add unit over XLEN cycles.
//  EBREAK and illegal ops enter a sticky halt state, which the simulation harness watches.
//  Holds the result until the WBU consumes it.
// PARAMETERS
//  XLEN   64             datapath width
//  CNT_W  $clog2(XLEN)   multiply iteration counter width
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     IDU presents an op
//  in_ready      out  1     sequencer can accept an op
//  in_op         in   2     00=ADD, 01=MUL, 10=EBREAK, 11=illegal
//  in_src1       in   XLEN  operand 1
//  in_src2       in   XLEN  operand 2
//  out_valid     out  1     result available to WBU
//  out_ready     in   1     WBU accepts result
//  out_result    out  XLEN  result
//  busy          out  1     state != IDLE
//  halt          out  1     EBREAK or illegal op retired (sticky)
//  halt_illegal  out  1     halt caused by illegal op (sticky)
// BEHAVIOUR
//  Reset: the async assert forces the following, even mid-operation:
//   - state=IDLE; counter=0.
//   - in_ready=0 while rst is high.
//   - out_valid=0, out_result=0, busy=0, halt=0, halt_illegal=0.
//  Accept: in_valid & in_ready on a rising edge latches in_op, in_src1 and in_src2.
//   - in_ready=1 only in IDLE. No accept in any other state, including DONE.
//  States:
//   - IDLE: on accept, branch on op:
//       ADD -> DONE, with out_result <= src1+src2 (mod 2^XLEN).
//       MUL -> MUL; load multiplicand/multiplier; acc=0; cnt=XLEN-1.
//       EBREAK -> HALT, halt<=1.
//       11 -> HALT, halt<=1, halt_illegal<=1.
//   - MUL: each cycle, if multiplier[0] then acc+=multiplicand.
//       Then multiplicand<<=1 and multiplier>>=1.
//       At cnt==0 go to DONE with out_result <= the low XLEN bits of acc; else cnt--.
//       Unsigned product, truncated: wrap-around is discarded.
//   - DONE: out_valid=1, out_result stable.
//       out_valid & out_ready -> IDLE, out_valid<=0 on the next edge.
//       Back-pressure is held indefinitely.
//   - HALT: absorbing until rst; in_ready=0, out_valid=0. halt and halt_illegal are held.
//  Latency, from the accept edge to the first out_valid=1 cycle:
//   - ADD: 1 cycle.
//   - MUL: XLEN+1 cycles (65 for XLEN=64).
//   - EBREAK: halt=1 one cycle after accept.
//  Throughput: one op per 2 cycles minimum, since DONE->IDLE->accept.
//  Operand changes on in_src* after accept have no effect.
//  rst deasserted mid-sequence: restarts cleanly from IDLE; no partial result is ever
//  presented.
// STRUCTURE
//  Shared package ysyx_22050039_pkg:
//   - localparams OP_ADD/OP_MUL/OP_EBREAK/OP_ILL (2-bit).
//   - state encodings S_IDLE/S_MUL/S_DONE/S_HALT (2-bit).
//  Sub-module ysyx_22050039_mul_iter:
//   - holds the multiplicand, multiplier, acc and cnt registers.
//   - ports: start, done, src1, src2, product.
//   - the sequencer FSM drives start and observes done.
//  Add path is an inline adder.
// TESTING
//  1. ADD 3+4, out_ready=1 -> out_valid=1 exactly 1 cycle after accept; out_result=7; back to IDLE.
//  2. MUL 0xFFFF_FFFF_FFFF_FFFF*2 -> out_result=0xFFFF_FFFF_FFFF_FFFE.
//     out_valid rises 65 cycles after accept.
//  3. MUL 0x8000_0000_0000_0000*4 -> out_result=0 (wrap).
//     ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> 0.
//  4. ADD 5+6 with out_ready=0 for 5 cycles -> out_valid=1 and out_result=11 stable.
//     in_ready=0 throughout; consumed on the 6th cycle.
//  5. EBREAK -> halt=1 next cycle, halt_illegal=0; further in_valid is never accepted.
//     op=11 -> halt=1, halt_illegal=1.
//  6. rst asserted 10 cycles into MUL -> immediately busy=0, out_valid=0.
//     After release, in_ready=1; next ADD 1+1 -> 2.

Source files
------------

// File: rtl/ysyx_22050039_pkg.sv
// Shared definitions for the execute-stage sequencer.
//   OP_*    : 2-bit opcode values presented on in_op by the IDU
//   state_t : sequencer FSM states
package ysyx_22050039_pkg;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_EBREAK = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10,
        S_HALT = 2'b11
    } state_t;

endpackage

// File: rtl/ysyx_22050039_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// The product is truncated to XLEN bits.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load src1/src2 and begin XLEN iterations
//   src1/src2 : multiplicand / multiplier, sampled only on start
//   done      : high during the final iteration; product is valid then
//   product   : accumulator value after the current iteration
module ysyx_22050039_mul_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] product
);
    import ysyx_22050039_pkg::*;

    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // product is the accumulator after this cycle's add, so the final
    // iteration can hand its result straight to the sequencer.
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = running & (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= src1;
            mplier  <= src2;
            acc     <= '0;
            cnt     <= CNT_W'(XLEN - 1);
            running <= 1'b1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ysyx_22050039_exu_sequencer.sv
// Execute-stage controller between IDU and WBU.
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/ready : op handshake from IDU (accept only in IDLE)
//   in_op          : 00 ADD, 01 MUL, 10 EBREAK, 11 illegal
//   in_src1/2      : operands, latched on accept
//   out_valid/ready: result handshake to WBU
//   out_result     : result, held until consumed
//   busy           : FSM not in IDLE
//   halt           : sticky, set by EBREAK or illegal op
//   halt_illegal   : sticky, set by illegal op
module ysyx_22050039_exu_sequencer #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic            halt,
    output logic            halt_illegal
);
    import ysyx_22050039_pkg::*;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic            res_load;
    logic [XLEN-1:0] res_next;
    logic            halt_set;
    logic            ill_set;

    // IDLE is the reset state, so rst is folded in to keep in_ready low
    // while reset is held.
    assign in_ready  = (state == S_IDLE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    ysyx_22050039_mul_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .src1    (in_src1),
        .src2    (in_src2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        res_load   = 1'b0;
        res_next   = out_result;
        halt_set   = 1'b0;
        ill_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_ADD: begin
                            state_next = S_DONE;
                            res_load   = 1'b1;
                            res_next   = in_src1 + in_src2;
                        end
                        OP_MUL: begin
                            state_next = S_MUL;
                            mul_start  = 1'b1;
                        end
                        OP_EBREAK: begin
                            state_next = S_HALT;
                            halt_set   = 1'b1;
                        end
                        default: begin
                            state_next = S_HALT;
                            halt_set   = 1'b1;
                            ill_set    = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_next = S_DONE;
                    res_load   = 1'b1;
                    res_next   = mul_product;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            out_result   <= '0;
            halt         <= 1'b0;
            halt_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (res_load) begin
                out_result <= res_next;
            end
            if (halt_set) begin
                halt <= 1'b1;
            end
            if (ill_set) begin
                halt_illegal <= 1'b1;
            end
        end
    end

endmodule
